// File: rtl/ifetch_queue.sv
// Instruction fetch queue: issues one instruction-memory request at a time and
// buffers returned words, tagged with their addresses, for the decode stage.
// A redirect from execute flushes the queue. A request still outstanding at
// that moment is drained through FLUSH, and its returned word is discarded.
module ifetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic [3:0]  count
);

    localparam int         PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] DEPTH_C = 4'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_WAIT  = 2'b01,
        ST_FLUSH = 2'b10
    } state_t;

    state_t             state_r;
    state_t             state_next_s;
    logic [31:0]        fetch_pc_r;
    logic [31:0]        fetch_pc_next_s;
    logic [31:0]        req_addr_r;
    logic [31:0]        req_addr_next_s;
    logic               mem_req_r;
    logic [3:0]         count_r;
    logic [3:0]         count_after_s;
    logic [PTR_W-1:0]   head_r;
    logic [PTR_W-1:0]   tail_r;
    logic [31:0]        pc_mem_r    [DEPTH];
    logic [31:0]        instr_mem_r [DEPTH];
    logic               push_s;
    logic               pop_s;
    logic               valid_s;

    assign valid_s   = (count_r != 4'd0);
    assign out_valid = valid_s;
    assign out_pc    = valid_s ? pc_mem_r[head_r]    : 32'h0000_0000;
    assign out_instr = valid_s ? instr_mem_r[head_r] : 32'h0000_0000;
    assign count     = count_r;
    assign mem_req   = mem_req_r;
    assign mem_addr  = req_addr_r;

    // Next-state, next fetch address and push/pop decode for the fetch FSM
    always_comb begin
        state_next_s    = state_r;
        fetch_pc_next_s = fetch_pc_r;
        req_addr_next_s = req_addr_r;
        // Only a returned word for a live (non-flushed) request is queued
        push_s          = (state_r == ST_WAIT) && mem_ack && !redirect;
        pop_s           = valid_s && out_ready;
        // Occupancy after this edge, used to decide whether to chain a request
        count_after_s   = count_r + {3'b000, push_s} - {3'b000, pop_s};
        case (state_r)
            ST_IDLE: begin
                if (redirect) begin
                    fetch_pc_next_s = redirect_pc;
                end else if (enable && (count_r < DEPTH_C)) begin
                    state_next_s    = ST_WAIT;
                    req_addr_next_s = fetch_pc_r;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (redirect) begin
                    fetch_pc_next_s = redirect_pc;
                    // Without the ack the memory still owes us a word: drain it
                    state_next_s    = mem_ack ? ST_IDLE : ST_FLUSH;
                end else if (mem_ack) begin
                    fetch_pc_next_s = fetch_pc_r + 32'd4;
                    if (enable && (count_after_s < DEPTH_C)) begin
                        req_addr_next_s = fetch_pc_r + 32'd4;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end else begin
                    state_next_s = ST_WAIT;
                end
            end
            ST_FLUSH: begin
                if (redirect) begin
                    fetch_pc_next_s = redirect_pc;
                end else begin
                    fetch_pc_next_s = fetch_pc_r;
                end
                if (mem_ack) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_FLUSH;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // FSM state, fetch address and registered memory request
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            fetch_pc_r <= RESET_PC;
            req_addr_r <= 32'h0000_0000;
            mem_req_r  <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            fetch_pc_r <= fetch_pc_next_s;
            req_addr_r <= req_addr_next_s;
            mem_req_r  <= (state_next_s != ST_IDLE);
        end
    end

    // Queue pointers and occupancy; a redirect empties the queue outright
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= 4'd0;
        end else if (redirect) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= 4'd0;
        end else begin
            if (push_s) begin
                tail_r <= tail_r + PTR_W'(1);
            end
            if (pop_s) begin
                head_r <= head_r + PTR_W'(1);
            end
            count_r <= count_after_s;
        end
    end

    // Queue storage: each entry keeps the fetch address alongside the word
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_r[i]    <= 32'h0000_0000;
                instr_mem_r[i] <= 32'h0000_0000;
            end
        end else if (push_s) begin
            pc_mem_r[tail_r]    <= req_addr_r;
            instr_mem_r[tail_r] <= mem_rdata;
        end
    end

endmodule
